// File: rtl/rng_arbiter.sv
// Round-robin arbiter sharing one external 16-bit xorshift PRNG.
// Discards WARMUP values after reset, then delivers one fresh value per grant.
module rng_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WARMUP  = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic               rnd_valid,
  output logic [15:0]        rnd_data,
  output logic               ready,
  output logic [15:0]        draw_count,
  output logic               prng_enable,
  input  logic [15:0]        prng_value
);

  localparam int PW = $clog2(NUM_REQ);

  typedef enum logic {
    WARM,
    RUN
  } state_t;

  localparam state_t RST_STATE =
    (WARMUP > 0) ? WARM : RUN;
  localparam logic [7:0] WARM_LAST =
    (WARMUP > 0) ? 8'(WARMUP - 1) : 8'd0;

  state_t             state;
  state_t             state_nx;
  logic [7:0]         warm_cnt;
  logic [7:0]         warm_cnt_nx;
  logic [PW-1:0]      ptr;
  logic [PW-1:0]      ptr_nx;
  logic [PW-1:0]      winner;
  logic               found;
  logic [NUM_REQ-1:0] elig;
  logic [NUM_REQ-1:0] gnt_nx;

  function automatic logic [PW-1:0] wrap_add(
    input logic [PW-1:0] a,
    input int            b
  );
    int s;
    s = int'(a) + b;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return PW'(s);
  endfunction

  // The requester granted this cycle is masked out of the next decision.
  assign elig = (state == RUN) ? (req & ~gnt) : '0;

  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && elig[wrap_add(ptr, i)]) begin
        found  = 1'b1;
        winner = wrap_add(ptr, i);
      end
    end
  end

  always_comb begin
    state_nx    = state;
    warm_cnt_nx = warm_cnt;
    ptr_nx      = ptr;
    gnt_nx      = '0;
    prng_enable = 1'b0;
    unique case (state)
      WARM: begin
        prng_enable = 1'b1;
        warm_cnt_nx = warm_cnt + 8'd1;
        if (warm_cnt == WARM_LAST) state_nx = RUN;
      end
      RUN: begin
        if (found) begin
          prng_enable = 1'b1;
          gnt_nx      = NUM_REQ'(1) << winner;
          ptr_nx      = wrap_add(winner, 1);
        end
      end
      default: state_nx = RST_STATE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= RST_STATE;
      warm_cnt   <= 8'd0;
      ptr        <= '0;
      gnt        <= '0;
      rnd_data   <= 16'd0;
      draw_count <= 16'd0;
    end else begin
      state    <= state_nx;
      warm_cnt <= warm_cnt_nx;
      ptr      <= ptr_nx;
      gnt      <= gnt_nx;
      if (|gnt_nx) begin
        rnd_data   <= prng_value;
        draw_count <= draw_count + 16'd1;
      end
    end
  end

  assign rnd_valid = |gnt;
  assign ready     = (state == RUN);

endmodule

// File: tb/tb_rng_arbiter.sv
// Bench for rng_arbiter: WARMUP=0 and WARMUP=8 instances,
// each fed by its own xorshift PRNG and checked against a sequence model.
module tb_rng_arbiter;

  logic        clk;
  logic        rst_n [2];
  logic [3:0]  req   [2];
  logic [3:0]  gnt   [2];
  logic        vld   [2];
  logic [15:0] data  [2];
  logic        rdy   [2];
  logic [15:0] cnt   [2];
  logic        en    [2];
  logic [15:0] px    [2];

  int n_pass = 0;
  int n_tot  = 0;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    rng_arbiter #(
      .NUM_REQ(4),
      .WARMUP (g == 0 ? 0 : 8)
    ) dut (
      .clk        (clk),
      .rst_n      (rst_n[g]),
      .req        (req[g]),
      .gnt        (gnt[g]),
      .rnd_valid  (vld[g]),
      .rnd_data   (data[g]),
      .ready      (rdy[g]),
      .draw_count (cnt[g]),
      .prng_enable(en[g]),
      .prng_value (px[g])
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [15:0] xs(input logic [15:0] v);
    logic [15:0] x;
    x = v;
    x = x ^ (x << 7);
    x = x ^ (x >> 9);
    x = x ^ (x << 8);
    return x;
  endfunction

  // External PRNG, sharing each instance's reset.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n[i]) px[i] <= 16'h0001;
      else if (en[i]) px[i] <= xs(px[i]);
    end
  end

  // Model: state = values consumed so far, next value, rr pointer.
  int          m_warm [2];
  int          m_ptr  [2];
  logic [3:0]  m_gnt  [2];
  logic [15:0] m_data [2];
  logic [15:0] m_cnt  [2];
  logic [15:0] m_x    [2];
  bit          started[2];

  task automatic model_step();
    logic [3:0] e;
    int j;
    for (int i = 0; i < 2; i++) begin
      if (!rst_n[i]) begin
        m_warm[i] = (i == 0) ? 0 : 8;
        m_ptr[i]  = 0;
        m_gnt[i]  = 4'b0;
        m_data[i] = 16'h0;
        m_cnt[i]  = 16'h0;
        m_x[i]    = 16'h0001;
      end else if (m_warm[i] > 0) begin
        m_warm[i] = m_warm[i] - 1;
        m_x[i]    = xs(m_x[i]);
        m_gnt[i]  = 4'b0;
      end else begin
        e        = req[i] & ~m_gnt[i];
        m_gnt[i] = 4'b0;
        for (int k = 0; k < 4; k++) begin
          j = (m_ptr[i] + k) % 4;
          if (e[j] && m_gnt[i] == 4'b0) begin
            m_gnt[i]  = 4'b1 << j;
            m_data[i] = m_x[i];
            m_x[i]    = xs(m_x[i]);
            m_ptr[i]  = (j + 1) % 4;
            m_cnt[i]  = m_cnt[i] + 16'd1;
          end
        end
      end
      started[i] = 1'b1;
    end
  endtask

  task automatic chk(
    input string       name,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_tot++;
    if (got !== exp)
      $display("FAIL %s got=%h want=%h", name, got, exp);
    else
      n_pass++;
  endtask

  initial begin
    started[0] = 1'b0;
    started[1] = 1'b0;
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  initial begin
    logic e_en;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (started[i]) begin
          e_en = (m_warm[i] > 0) ||
                 ((req[i] & ~m_gnt[i]) != 4'b0);
          chk($sformatf("gnt%0d", i), 32'(gnt[i]), 32'(m_gnt[i]));
          chk($sformatf("vld%0d", i), 32'(vld[i]),
              32'(m_gnt[i] != 4'b0));
          chk($sformatf("data%0d", i), 32'(data[i]), 32'(m_data[i]));
          chk($sformatf("cnt%0d", i), 32'(cnt[i]), 32'(m_cnt[i]));
          chk($sformatf("rdy%0d", i), 32'(rdy[i]),
              32'(m_warm[i] == 0));
          chk($sformatf("en%0d", i), 32'(en[i]), 32'(e_en));
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    logic [3:0] order [5];
    order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    rst_n[0] = 1'b0;
    rst_n[1] = 1'b0;
    req[0]   = 4'b0;
    req[1]   = 4'b0;
    tick(1);

    // T2: warmup of 8 with all requesters held
    rst_n[1] = 1'b1;
    req[1]   = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      chk("t2_warm_en", 32'(en[1]), 32'd1);
      chk("t2_warm_rdy", 32'(rdy[1]), 32'd0);
      chk("t2_warm_gnt", 32'(gnt[1]), 32'd0);
      tick(1);
    end
    chk("t2_rdy", 32'(rdy[1]), 32'd1);
    chk("t2_gnt0", 32'(gnt[1]), 32'd0);
    for (int k = 0; k < 5; k++) begin
      tick(1);
      chk($sformatf("t2_order%0d", k), 32'(gnt[1]), 32'(order[k]));
    end
    req[1] = 4'b0;

    // T1: single draws from WARMUP=0 instance
    chk("t1_rst_gnt", 32'(gnt[0]), 32'd0);
    chk("t1_rst_cnt", 32'(cnt[0]), 32'd0);
    chk("t1_rst_data", 32'(data[0]), 32'd0);
    chk("t1_rst_rdy", 32'(rdy[0]), 32'd1);
    rst_n[0] = 1'b1;
    req[0]   = 4'b0001;
    tick(1);
    chk("t1_gnt", 32'(gnt[0]), 32'h1);
    chk("t1_data", 32'(data[0]), 32'h0001);
    chk("t1_cnt", 32'(cnt[0]), 32'd1);
    req[0] = 4'b0;
    tick(1);
    chk("t1_idle", 32'(gnt[0]), 32'd0);
    req[0] = 4'b0001;
    tick(1);
    chk("t1_data2", 32'(data[0]), 32'h8181);
    chk("t1_cnt2", 32'(cnt[0]), 32'd2);
    req[0] = 4'b0;
    tick(1);

    // T3: all held, model checks every cycle
    req[0] = 4'b1111;
    tick(1);
    chk("t3_first", 32'(gnt[0]), 32'b0010);
    tick(12);
    req[0] = 4'b0;
    tick(2);

    // T4: pointer after grant to requester 2
    req[0] = 4'b0100;
    tick(1);
    chk("t4_g2", 32'(gnt[0]), 32'b0100);
    req[0] = 4'b0;
    tick(1);
    req[0] = 4'b0101;
    tick(1);
    chk("t4_g0", 32'(gnt[0]), 32'b0001);
    tick(1);
    chk("t4_g2b", 32'(gnt[0]), 32'b0100);
    req[0] = 4'b0;
    tick(2);

    // T5: reset mid-operation restarts the sequence
    req[0] = 4'b1111;
    tick(3);
    rst_n[0] = 1'b0;
    req[0]   = 4'b0;
    tick(1);
    chk("t5_gnt", 32'(gnt[0]), 32'd0);
    chk("t5_cnt", 32'(cnt[0]), 32'd0);
    chk("t5_data", 32'(data[0]), 32'd0);
    rst_n[0] = 1'b1;
    req[0]   = 4'b0001;
    tick(1);
    chk("t5_regnt", 32'(gnt[0]), 32'h1);
    chk("t5_redata", 32'(data[0]), 32'h0001);
    chk("t5_recnt", 32'(cnt[0]), 32'd1);
    req[0] = 4'b0;
    tick(1);

    // T6: draw_count wraps
    req[0] = 4'b1111;
    tick(16'hFFFE);
    chk("t6_ffff", 32'(cnt[0]), 32'hFFFF);
    tick(1);
    chk("t6_wrap", 32'(cnt[0]), 32'h0000);
    req[0] = 4'b0;
    tick(3);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
